// File: rtl/esc_spi_engine.sv
// Hardware SPI master that runs complete EtherCAT ESC register read/write
// transactions (header, wait state, data) from a single-word request.
module esc_spi_engine #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [12:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    input  logic        esc_eepdone,
    output logic        esc_ready,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state_r;
    logic        eep_meta_r;
    logic [54:0] tx_r;
    logic [31:0] rx_r;
    logic [5:0]  bit_idx_r;
    logic [5:0]  last_bit_r;
    logic        rd_r;
    logic [15:0] cnt_r;
    logic [55:0] frame_s;
    logic [2:0]  nbytes_m1_s;
    logic [4:0]  data_bit_s;
    logic [4:0]  rx_pos_s;

    // Whole MOSI frame, MSB-first and left-aligned; unused trailing bits are zero.
    function automatic logic [55:0] build_frame(
        input logic        wr,
        input logic [12:0] addr,
        input logic [1:0]  len,
        input logic [31:0] wdata
    );
        logic [55:0] f;
        f = 56'h0;
        f[55:48] = addr[12:5];
        f[47:40] = {addr[4:0], (wr ? 3'b100 : 3'b011)};
        for (int i = 0; i < 4; i++) begin
            if (wr) begin
                if (i <= int'(len)) f[39-8*i -: 8] = wdata[8*i +: 8];
                else                f[39-8*i -: 8] = 8'h00;
            end else begin
                if (i == int'(len)) f[31-8*i -: 8] = 8'hFF;
                else                f[31-8*i -: 8] = 8'h00;
            end
        end
        if (!wr) f[39:32] = 8'hFF;
        return f;
    endfunction

    // Request decode: outgoing frame for the word presented on the request port.
    always_comb begin
        frame_s = build_frame(req_write, req_addr, req_len, req_wdata);
    end

    assign nbytes_m1_s = 3'd2 + {2'b00, ~req_write} + {1'b0, req_len};
    // Read data starts after 24 header/wait bits; the byte index and MSB-first bit slot fall out of the low bits.
    assign data_bit_s  = bit_idx_r[4:0] - 5'd24;
    assign rx_pos_s    = {data_bit_s[4:3], ~data_bit_s[2:0]};

    assign req_ready = esc_ready & (state_r == IDLE);

    // Two-flop synchronizer for the asynchronous EEPROM-done input.
    always_ff @(posedge clk) begin
        if (reset) begin
            eep_meta_r <= 1'b0;
            esc_ready  <= 1'b0;
        end else begin
            eep_meta_r <= esc_eepdone;
            esc_ready  <= eep_meta_r;
        end
    end

    // Transaction sequencer: chip-select framing, SCLK generation, shift in/out, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tx_r       <= 55'h0;
            rx_r       <= 32'h0;
            bit_idx_r  <= 6'd0;
            last_bit_r <= 6'd0;
            rd_r       <= 1'b0;
            cnt_r      <= 16'd0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b1;
            spi_mosi   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        tx_r       <= frame_s[54:0];
                        spi_mosi   <= frame_s[55];
                        rd_r       <= ~req_write;
                        last_bit_r <= {nbytes_m1_s, 3'b111};
                        rx_r       <= 32'h0;
                        bit_idx_r  <= 6'd0;
                        spi_cs_n   <= 1'b0;
                        busy       <= 1'b1;
                        cnt_r      <= 16'(CS_SETUP - 1);
                        state_r    <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    if (cnt_r == 16'd0) begin
                        spi_sclk <= 1'b0;
                        cnt_r    <= 16'(CLK_DIV - 1);
                        state_r  <= SHIFT;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_r != 16'd0) begin
                        cnt_r <= cnt_r - 16'd1;
                    end else if (!spi_sclk) begin
                        spi_sclk <= 1'b1;
                        cnt_r    <= 16'(CLK_DIV - 1);
                        if (rd_r && (bit_idx_r >= 6'd24)) begin
                            rx_r[rx_pos_s] <= spi_miso;
                        end
                    end else if (bit_idx_r == last_bit_r) begin
                        cnt_r   <= 16'(CS_HOLD - 1);
                        state_r <= HOLD;
                    end else begin
                        spi_sclk  <= 1'b0;
                        spi_mosi  <= tx_r[54];
                        tx_r      <= {tx_r[53:0], 1'b0};
                        bit_idx_r <= bit_idx_r + 6'd1;
                        cnt_r     <= 16'(CLK_DIV - 1);
                    end
                end
                HOLD: begin
                    if (cnt_r == 16'd0) begin
                        spi_cs_n  <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_r ? rx_r : 32'h0;
                        cnt_r     <= 16'(2 * CLK_DIV - 1);
                        state_r   <= GAP;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                GAP: begin
                    if (cnt_r == 16'd0) begin
                        busy     <= 1'b0;
                        spi_mosi <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esc_spi_engine.sv
// Self-checking bench for esc_spi_engine: directed vector table, random
// transactions against a byte-level reference model, reset and back-to-back cases.
module tb_esc_spi_engine;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [12:0] req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        esc_eepdone;
    logic        esc_ready;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b1;

    esc_spi_engine #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .esc_eepdone(esc_eepdone), .esc_ready(esc_ready),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pin-level observer and ESC slave model; it owns every variable it writes.
    logic [55:0] slave_frame = 56'h0;
    logic [55:0] mosi_cap    = 56'h0;
    logic        mosi_at_cs  = 1'b0;
    logic [31:0] rsp_data    = 32'h0;
    int frame_fall = 0, frame_rise = 0, first_fall = -1, last_rise = -1;
    int cs_fall_cyc = -1, rsp_cyc = -1, rsp_cnt = 0, busy_fall = -1, idle_err = 0;
    logic prev_sclk = 1'b1, prev_cs = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (spi_cs_n === 1'b1 && spi_sclk !== 1'b1) idle_err++;
        if (spi_cs_n === 1'b0 && prev_cs) begin
            cs_fall_cyc = cyc;
            mosi_at_cs  = spi_mosi;
            frame_fall  = 0;
            frame_rise  = 0;
            mosi_cap    = 56'h0;
        end
        if (spi_cs_n === 1'b0 && prev_sclk && spi_sclk === 1'b0) begin
            if (frame_fall == 0) first_fall = cyc;
            if (frame_fall < 56) spi_miso = slave_frame[55 - frame_fall];
            frame_fall++;
        end
        if (spi_cs_n === 1'b0 && !prev_sclk && spi_sclk === 1'b1) begin
            if (frame_rise < 56) mosi_cap[55 - frame_rise] = spi_mosi;
            last_rise = cyc;
            frame_rise++;
        end
        if (rsp_valid === 1'b1) begin
            rsp_cyc  = cyc;
            rsp_data = rsp_rdata;
            rsp_cnt++;
        end
        if (prev_busy && busy === 1'b0) busy_fall = cyc;
        prev_sclk = (spi_sclk === 1'b1);
        prev_cs   = (spi_cs_n !== 1'b0);
        prev_busy = (busy === 1'b1);
    end

    // Reference model: the ESC frame as a list of bytes, and the expected response word.
    task automatic model(input logic wr, input logic [12:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, input logic [31:0] sdata,
                         output logic [55:0] frame, output int nbits, output logic [31:0] rdata);
        logic [7:0] q[$];
        q.push_back(addr[12:5]);
        q.push_back({addr[4:0], (wr ? 3'b100 : 3'b011)});
        if (!wr) q.push_back(8'hFF);
        for (int i = 0; i <= int'(len); i++) begin
            if (wr) q.push_back(wdata[8*i +: 8]);
            else    q.push_back((i == int'(len)) ? 8'hFF : 8'h00);
        end
        nbits = 8 * q.size();
        frame = 56'h0;
        foreach (q[i]) frame[55 - 8*i -: 8] = q[i];
        rdata = 32'h0;
        if (!wr) for (int i = 0; i <= int'(len); i++) rdata[8*i +: 8] = sdata[8*i +: 8];
    endtask

    // One transaction: present the request, wait for accept, completion and end of gap, then check.
    task automatic do_txn(input string tag, input logic wr, input logic [12:0] addr,
                          input logic [1:0] len, input logic [31:0] wdata, input logic [31:0] sdata,
                          input logic hold, input logic [55:0] ef, input int nbits,
                          input logic [31:0] er, output int t);
        logic [63:0] r64;
        int guard;
        int rsp_before;
        r64 = {$urandom, $urandom};
        slave_frame = r64[55:0];
        if (!wr) for (int i = 0; i < 4; i++) slave_frame[31 - 8*i -: 8] = sdata[8*i +: 8];
        req_write = wr; req_addr = addr; req_len = len; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 2000) begin @(negedge clk); #1; guard++; end
        check({tag, " accept_timeout"}, 64'(guard < 2000), 64'd1);
        t = cyc;
        rsp_before = rsp_cnt;
        @(negedge clk); #1;
        if (!hold) req_valid = 1'b0;
        guard = 0;
        while (rsp_cnt == rsp_before && guard < 3000) begin @(negedge clk); #1; guard++; end
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin @(negedge clk); #1; guard++; end
        check({tag, " cs_fall"},    64'(cs_fall_cyc), 64'(t + 1));
        check({tag, " mosi_first"}, 64'(mosi_at_cs),  64'(ef[55]));
        check({tag, " first_fall"}, 64'(first_fall),  64'(t + 1 + CS_SETUP));
        check({tag, " rise_count"}, 64'(frame_rise),  64'(nbits));
        check({tag, " last_rise"},  64'(last_rise),   64'(t + CS_SETUP + nbits*2*CLK_DIV - CLK_DIV + 1));
        check({tag, " mosi_frame"}, 64'(mosi_cap),    64'(ef));
        check({tag, " rsp_count"},  64'(rsp_cnt),     64'(rsp_before + 1));
        check({tag, " rsp_cycle"},  64'(rsp_cyc),     64'(t + 1 + CS_SETUP + nbits*2*CLK_DIV + CS_HOLD));
        check({tag, " rsp_rdata"},  64'(rsp_data),    64'(er));
        check({tag, " busy_fall"},  64'(busy_fall),   64'(rsp_cyc + 2*CLK_DIV));
    endtask

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic [55:0] exp_frame;
        int          nbits;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t        tbl[3];
        logic [55:0] ef;
        logic [31:0] er;
        int          nb, t, t2, first_rsp, rsp_before;
        logic        wr;
        logic [12:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata, sdata;
        int          seen_ready;

        tbl[0] = '{1'b1, 13'h0120, 2'd0, 32'h0000_00A5, 32'h5A5A_5A5A, 56'h0904A5_0000_0000, 24, 32'h0};
        tbl[1] = '{1'b0, 13'h0064, 2'd3, 32'h0000_0000, 32'h4433_2211, 56'h0323FF_000000FF, 56, 32'h4433_2211};
        tbl[2] = '{1'b0, 13'h1ABC, 2'd1, 32'h0000_0000, 32'h7766_CDAB, 56'hD5E3FF00FF_0000,   40, 32'h0000_CDAB};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 13'h0;
        req_len = 2'd0; req_wdata = 32'h0; esc_eepdone = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cs_n",  64'(spi_cs_n),  64'd1);
        check("reset sclk",  64'(spi_sclk),  64'd1);
        check("reset mosi",  64'(spi_mosi),  64'd0);
        check("reset ready", 64'(req_ready), 64'd0);
        check("reset rsp",   64'({rsp_valid, rsp_rdata, busy, esc_ready}), 64'd0);
        #1 reset = 1'b0;

        // EEPROM gating with the first table vector held on the request port.
        req_write = tbl[0].wr; req_addr = tbl[0].addr; req_len = tbl[0].len;
        req_wdata = tbl[0].wdata; req_valid = 1'b1;
        seen_ready = 0;
        repeat (20) begin @(negedge clk); if (req_ready !== 1'b0) seen_ready++; end
        check("gate ready_low", 64'(seen_ready), 64'd0);
        #1 esc_eepdone = 1'b1;
        @(negedge clk);
        check("gate ready_plus1", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("gate ready_plus2", 64'(req_ready), 64'd1);
        #1;

        for (int i = 0; i < 3; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].wdata,
                   tbl[i].sdata, 1'b0, tbl[i].exp_frame, tbl[i].nbits, tbl[i].exp_rdata, t);
            repeat (3) @(negedge clk);
            #1;
        end

        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom); addr = 13'($urandom); len = 2'($urandom);
            wdata = $urandom; sdata = $urandom;
            model(wr, addr, len, wdata, sdata, ef, nb, er);
            do_txn($sformatf("rnd%0d", i), wr, addr, len, wdata, sdata, 1'b0, ef, nb, er, t);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #1;
        end

        // Reset in the middle of the shift phase aborts silently.
        req_write = 1'b0; req_addr = 13'h0A5A; req_len = 2'd3; req_valid = 1'b1;
        seen_ready = 0;
        while (req_ready !== 1'b1 && seen_ready < 100) begin @(negedge clk); #1; seen_ready++; end
        @(negedge clk); #1 req_valid = 1'b0;
        repeat (60) @(negedge clk);
        #1 reset = 1'b1;
        rsp_before = rsp_cnt;
        @(negedge clk);
        check("midreset cs_n",  64'(spi_cs_n),  64'd1);
        check("midreset sclk",  64'(spi_sclk),  64'd1);
        check("midreset mosi",  64'(spi_mosi),  64'd0);
        check("midreset outs",  64'({req_ready, rsp_valid, rsp_rdata, busy, esc_ready}), 64'd0);
        @(negedge clk); #1 reset = 1'b0;
        repeat (500) @(negedge clk);
        check("midreset no_rsp", 64'(rsp_cnt), 64'(rsp_before));
        #1;
        wr = 1'b0; addr = 13'($urandom); len = 2'd2; wdata = 32'h0; sdata = $urandom;
        model(wr, addr, len, wdata, sdata, ef, nb, er);
        do_txn("post_reset", wr, addr, len, wdata, sdata, 1'b0, ef, nb, er, t);

        // Back-to-back with req_valid held across the gap.
        wr = 1'b1; addr = 13'h0F10; len = 2'd1; wdata = 32'h0000_BEEF; sdata = 32'h0;
        model(wr, addr, len, wdata, sdata, ef, nb, er);
        do_txn("b2b_a", wr, addr, len, wdata, sdata, 1'b1, ef, nb, er, t);
        first_rsp = rsp_cyc;
        wr = 1'b0; addr = 13'h0130; len = 2'd0; sdata = 32'h0000_0096;
        model(wr, addr, len, wdata, sdata, ef, nb, er);
        do_txn("b2b_b", wr, addr, len, wdata, sdata, 1'b0, ef, nb, er, t2);
        check("b2b spacing", 64'(cs_fall_cyc - first_rsp), 64'(2*CLK_DIV + 1));

        check("sclk idle high", 64'(idle_err), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
